// File: rtl/arb_mux4x1.sv
// Four-channel round-robin merge into a single-entry output register.
// Each word leaves tagged with its source index (a=00, b=01, c=10, d=11).
module arb_mux4x1 #(
    parameter int DATA_WIDTH = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] in_a,
    input  logic [DATA_WIDTH-1:0] in_b,
    input  logic [DATA_WIDTH-1:0] in_c,
    input  logic [DATA_WIDTH-1:0] in_d,
    input  logic                  valid_a,
    input  logic                  valid_b,
    input  logic                  valid_c,
    input  logic                  valid_d,
    output logic                  ready_a,
    output logic                  ready_b,
    output logic                  ready_c,
    output logic                  ready_d,
    output logic [DATA_WIDTH-1:0] out,
    output logic [1:0]            out_select,
    output logic                  out_valid,
    input  logic                  out_ready
);

    logic [DATA_WIDTH-1:0] out_q, out_d;
    logic [1:0]            sel_q, sel_d;
    logic [1:0]            last_q, last_d;
    logic                  oval_q, oval_d;

    logic [3:0]            req_s;
    logic [3:0]            grant_s;
    logic [1:0]            win_s;
    logic [1:0]            cand_s;
    logic                  found_s;
    logic                  load_s;
    logic                  drain_s;
    logic [DATA_WIDTH-1:0] win_data_s;

    // Round-robin search from last+1 and the resulting one-hot grant.
    always_comb begin
        req_s   = {valid_d, valid_c, valid_b, valid_a};
        found_s = 1'b0;
        win_s   = 2'b00;
        cand_s  = 2'b00;
        for (int i = 1; i <= 4; i++) begin
            cand_s  = last_q + 2'(i);
            win_s   = (!found_s && req_s[cand_s]) ? cand_s : win_s;
            found_s = found_s | req_s[cand_s];
        end
        // Reset gates the grant so no source sees a handshake in the reset cycle.
        load_s  = ~reset & enable & (~oval_q | out_ready) & found_s;
        drain_s = oval_q & out_ready;
        grant_s = load_s ? (4'b0001 << win_s) : 4'b0000;
    end

    // Winner data select.
    always_comb begin
        case (win_s)
            2'b00:   win_data_s = in_a;
            2'b01:   win_data_s = in_b;
            2'b10:   win_data_s = in_c;
            2'b11:   win_data_s = in_d;
            default: win_data_s = in_a;
        endcase
    end

    // Next-state for the output register and round-robin pointer.
    always_comb begin
        out_d  = out_q;
        sel_d  = sel_q;
        oval_d = oval_q;
        last_d = last_q;
        if (load_s) begin
            out_d  = win_data_s;
            sel_d  = win_s;
            oval_d = 1'b1;
            last_d = win_s;
        end else if (drain_s) begin
            oval_d = 1'b0;
        end else begin
            oval_d = oval_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_q  <= {DATA_WIDTH{1'b0}};
            sel_q  <= 2'b00;
            oval_q <= 1'b0;
            last_q <= 2'b11;
        end else begin
            out_q  <= out_d;
            sel_q  <= sel_d;
            oval_q <= oval_d;
            last_q <= last_d;
        end
    end

    assign ready_a    = grant_s[0];
    assign ready_b    = grant_s[1];
    assign ready_c    = grant_s[2];
    assign ready_d    = grant_s[3];
    assign out        = out_q;
    assign out_select = sel_q;
    assign out_valid  = oval_q;

endmodule

// File: tb/tb_arb_mux4x1.sv
// Directed bench for arb_mux4x1: stimulus pushes hand-computed words into a
// scoreboard queue; a negedge monitor pops and compares on every drained word.
module tb_arb_mux4x1;

    localparam int DW = 8;

    logic          clk;
    logic          reset;
    logic          enable;
    logic [DW-1:0] in_a, in_b, in_c, in_d;
    logic          valid_a, valid_b, valid_c, valid_d;
    logic          ready_a, ready_b, ready_c, ready_d;
    logic [DW-1:0] out;
    logic [1:0]    out_select;
    logic          out_valid;
    logic          out_ready;

    logic [3:0]    rdy;
    assign rdy = {ready_d, ready_c, ready_b, ready_a};

    int n_total = 0;
    int n_pass  = 0;
    logic [DW+1:0] sb[$];

    arb_mux4x1 #(.DATA_WIDTH(DW)) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_d(in_d),
        .valid_a(valid_a), .valid_b(valid_b), .valid_c(valid_c), .valid_d(valid_d),
        .ready_a(ready_a), .ready_b(ready_b), .ready_c(ready_c), .ready_d(ready_d),
        .out(out), .out_select(out_select), .out_valid(out_valid), .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [DW-1:0] data_of(input logic [1:0] s);
        case (s)
            2'b00:   return 8'hA1;
            2'b01:   return 8'h01;
            2'b10:   return 8'hC3;
            default: return 8'hD4;
        endcase
    endfunction

    task automatic push(input logic [1:0] s);
        sb.push_back({s, data_of(s)});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] v, input logic en, input logic ordy);
        {valid_d, valid_c, valid_b, valid_a} = v;
        enable    = en;
        out_ready = ordy;
        #1;
    endtask

    // Monitor: every word accepted by the sink must match the scoreboard head.
    always @(negedge clk) begin
        if (reset === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_word", {22'd0, out_select, out}, 32'hFFFF_FFFF);
            end else begin
                check("drained_word", {22'd0, out_select, out}, {22'd0, sb.pop_front()});
            end
        end
    end

    initial begin
        in_a = 8'hA1; in_b = 8'h01; in_c = 8'hC3; in_d = 8'hD4;
        reset = 1'b1;
        {valid_d, valid_c, valid_b, valid_a} = 4'b0000;
        enable = 1'b1;
        out_ready = 1'b0;

        // Reset state, and no grant during a reset cycle even with all requests.
        tick();
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out", out, 8'h00);
        check("rst_out_select", out_select, 2'b00);
        drive(4'b1111, 1'b1, 1'b1);
        check("rst_ready", rdy, 4'b0000);
        tick();
        reset = 1'b0;

        // Single b request.
        drive(4'b0010, 1'b1, 1'b1);
        check("b_ready", rdy, 4'b0010);
        push(2'b01);
        tick();
        check("b_out_valid", out_valid, 1'b1);
        check("b_out_select", out_select, 2'b01);
        check("b_out", out, 8'h01);
        // last=01 now, so c wins next.
        drive(4'b1111, 1'b1, 1'b1);
        check("after_b_ready", rdy, 4'b0100);
        push(2'b10);
        tick();
        drive(4'b0000, 1'b1, 1'b1);
        tick();

        // last=10 with only b and d requesting: d then b.
        drive(4'b1010, 1'b1, 1'b1);
        check("bd_first_ready", rdy, 4'b1000);
        push(2'b11);
        tick();
        drive(4'b1010, 1'b1, 1'b1);
        check("bd_second_ready", rdy, 4'b0010);
        push(2'b01);
        tick();
        drive(4'b0000, 1'b1, 1'b1);
        tick();

        // Fresh reset, then all four requesting: a,b,c,d,a,b,c,d.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive(4'b1111, 1'b1, 1'b1);
            check("rotate_ready", rdy, 4'b0001 << (i % 4));
            push(2'(i % 4));
            tick();
        end
        drive(4'b0000, 1'b1, 1'b1);
        tick();

        // Load c, then stall five cycles with a requesting.
        drive(4'b0100, 1'b1, 1'b1);
        check("stall_load_ready", rdy, 4'b0100);
        push(2'b10);
        tick();
        for (int i = 0; i < 5; i++) begin
            drive(4'b0001, 1'b1, 1'b0);
            check("stall_ready", rdy, 4'b0000);
            check("stall_out_select", out_select, 2'b10);
            check("stall_out", out, 8'hC3);
            check("stall_out_valid", out_valid, 1'b1);
            tick();
        end
        drive(4'b0001, 1'b1, 1'b1);
        check("unstall_ready", rdy, 4'b0001);
        push(2'b00);
        tick();
        check("unstall_out_select", out_select, 2'b00);
        check("unstall_out_valid", out_valid, 1'b1);

        // Enable low: word drains, d is not granted, pointer stays at a.
        drive(4'b1000, 1'b0, 1'b1);
        check("dis_ready_full", rdy, 4'b0000);
        tick();
        check("dis_out_valid", out_valid, 1'b0);
        drive(4'b1000, 1'b0, 1'b1);
        check("dis_ready_empty", rdy, 4'b0000);
        tick();
        check("dis_hold_valid", out_valid, 1'b0);
        drive(4'b1000, 1'b1, 1'b1);
        check("reen_ready", rdy, 4'b1000);
        push(2'b11);
        tick();
        drive(4'b0000, 1'b1, 1'b1);
        tick();

        // Reset while FULL and stalled: held word is discarded.
        drive(4'b0001, 1'b1, 1'b1);
        check("pre_rst_ready", rdy, 4'b0001);
        push(2'b00);
        tick();
        drive(4'b0001, 1'b1, 1'b0);
        reset = 1'b1;
        #1;
        check("mid_rst_ready", rdy, 4'b0000);
        void'(sb.pop_back());
        tick();
        reset = 1'b0;
        check("mid_rst_out_valid", out_valid, 1'b0);
        check("mid_rst_out", out, 8'h00);
        check("mid_rst_out_select", out_select, 2'b00);
        drive(4'b1111, 1'b1, 1'b1);
        check("post_rst_ready", rdy, 4'b0001);
        push(2'b00);
        tick();
        drive(4'b0000, 1'b1, 1'b1);
        tick();
        tick();

        check("scoreboard_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
